// File: rtl/fib_arb_pkg.sv
// Shared types and widths for the Fibonacci engine request arbiter.
package fib_arb_pkg;
  localparam int ANS_W    = 121;
  localparam int N_W      = 5;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;
  localparam int CYW_DEF  = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            valid,
  output logic [IDW-1:0]  id
);
  int idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx]) begin
        valid = 1'b1;
        id    = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/fib_req_arbiter.sv
// Round-robin arbiter sharing one Fibonacci engine among NREQ requesters,
// one transaction in flight, with a registered response holding stage.
module fib_req_arbiter
  import fib_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF,
  parameter int CYW  = CYW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [N_W*NREQ-1:0]   req_n,
  output logic [NREQ-1:0]       gnt,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [ANS_W-1:0]      resp_ans,
  output logic [CYW-1:0]        resp_cycles,
  output logic                  eng_start,
  output logic [N_W-1:0]        eng_n,
  input  logic                  eng_done,
  input  logic [ANS_W-1:0]      eng_ans
);
  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr, id_q, pick_id, ptr_nxt;
  logic             pick_vld, take, cap, hs, cnt_en;
  logic [CYW-1:0]   cnt_q;
  logic [N_W-1:0]   pick_n;
  logic [NREQ-1:0]  pick_oh;

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .id     (pick_id)
  );

  always_comb begin
    pick_n  = '0;
    pick_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == IDW'(i)) begin
        pick_n     = req_n[i*N_W +: N_W];
        pick_oh[i] = 1'b1;
      end
    end
  end

  assign ptr_nxt = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    cap     = 1'b0;
    hs      = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE:      if (pick_vld) begin take = 1'b1; state_d = LAUNCH; end
      LAUNCH:    state_d = WAIT_BUSY;
      // Done must be seen low first so a stale "idle" level is never taken as completion.
      WAIT_BUSY: if (!eng_done) begin cnt_en = 1'b1; state_d = WAIT_DONE; end
      WAIT_DONE: begin
        if (eng_done) begin cap = 1'b1; state_d = RESP; end
        else cnt_en = 1'b1;
      end
      RESP:      if (resp_ready) begin hs = 1'b1; state_d = IDLE; end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      gnt         <= '0;
      eng_start   <= 1'b0;
      eng_n       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_ans    <= '0;
      resp_cycles <= '0;
    end else begin
      gnt       <= '0;
      eng_start <= 1'b0;
      if (take) begin
        id_q      <= pick_id;
        gnt       <= pick_oh;
        eng_start <= 1'b1;
        eng_n     <= pick_n;
        cnt_q     <= '0;
      end
      if (cnt_en && cnt_q != '1) cnt_q <= cnt_q + CYW'(1);
      if (cap) begin
        resp_valid  <= 1'b1;
        resp_id     <= id_q;
        resp_ans    <= eng_ans;
        resp_cycles <= cnt_q;
        eng_n       <= '0;
      end
      if (hs) begin
        resp_valid <= 1'b0;
        rr_ptr     <= ptr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_fib_req_arbiter.sv
// Directed scoreboard bench for fib_req_arbiter with a behavioural engine model.
module tb_fib_req_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CYW  = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [5*NREQ-1:0]  req_n;
  logic [NREQ-1:0]    gnt;
  logic               resp_valid, resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [120:0]       resp_ans;
  logic [CYW-1:0]     resp_cycles;
  logic               eng_start;
  logic [4:0]         eng_n;
  logic               eng_done;
  logic [120:0]       eng_ans;

  fib_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .CYW(CYW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_n(req_n), .gnt(gnt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_ans(resp_ans), .resp_cycles(resp_cycles), .eng_start(eng_start),
    .eng_n(eng_n), .eng_done(eng_done), .eng_ans(eng_ans)
  );

  always #5 clk = ~clk;

  function automatic logic [120:0] fib(input int n);
    logic [120:0] a, b, t;
    a = '0; b = 121'd1;
    for (int i = 0; i < n; i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  // Engine model: done stays high eng_hi cycles after start, then low eng_busy cycles.
  int         eng_hi = 0, eng_busy = 6, tick;
  logic [4:0] n_lat;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick  <= 0;
      n_lat <= '0;
    end else if (eng_start) begin
      tick  <= 1;
      n_lat <= eng_n;
    end else if (tick != 0) begin
      tick <= (tick >= eng_hi + eng_busy) ? 0 : tick + 1;
    end
  end
  assign eng_done = !(tick > eng_hi && tick <= eng_hi + eng_busy);
  assign eng_ans  = fib(int'(n_lat));

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [120:0]   ans;
    logic [CYW-1:0] cyc;
  } exp_t;
  exp_t sb[$];
  exp_t last;
  int   total = 0, bad = 0;
  int   gh[5];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input int n, input int busy);
    exp_t e;
    e.id  = IDW'(id);
    e.ans = fib(n);
    e.cyc = (busy > 1023) ? CYW'(1023) : CYW'(busy);
    sb.push_back(e);
  endtask

  task automatic set_n(input int i, input int n);
    req_n[i*5 +: 5] = 5'(n);
  endtask

  task automatic wait_gnt(input string tag, input logic [NREQ-1:0] eg, input int en);
    int k;
    k = 0;
    @(negedge clk);
    while (gnt == '0 && k < 200) begin @(negedge clk); k++; end
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_start"}, eng_start, 1'b1);
    chk({tag, "_eng_n"}, eng_n, en);
  endtask

  task automatic wait_resp(input string tag, input int max);
    int k;
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < max) begin @(negedge clk); k++; end
    chk({tag, "_valid"}, resp_valid, 1'b1);
    last = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_id"}, resp_id, last.id);
    chk({tag, "_ans"}, resp_ans, last.ans);
    chk({tag, "_cyc"}, resp_cycles, last.cyc);
  endtask

  initial begin
    reset = 1'b0; req = '0; req_n = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_ans", resp_ans, 0);
    chk("rst_cyc", resp_cycles, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_eng_n", eng_n, 0);
    reset = 1'b1;

    // Single request from requester 2.
    @(negedge clk);
    eng_hi = 0; eng_busy = 6;
    set_n(2, 5); req = 4'b0100; push(2, 5, 6);
    wait_gnt("single", 4'b0100, 5);
    req = '0;
    wait_resp("single", 100);

    // Abort mid-flight with reset.
    @(negedge clk);
    eng_busy = 20; set_n(3, 3); req = 4'b1000;
    wait_gnt("abort", 4'b1000, 3);
    req = '0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_valid", resp_valid, 0);
    chk("abort_start", eng_start, 0);
    chk("abort_eng_n", eng_n, 0);
    chk("abort_ans", resp_ans, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_gnt", gnt, 0);
      chk("post_abort_valid", resp_valid, 0);
    end
    eng_busy = 2; set_n(0, 4); req = 4'b0001; push(0, 4, 2);
    wait_gnt("after_rst", 4'b0001, 4);
    req = '0;
    wait_resp("after_rst", 100);

    // Fresh reset so the pointer starts at 0, then all four request continuously.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    eng_busy = 3;
    for (int i = 0; i < NREQ; i++) set_n(i, 8 + i);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      push(g % 4, 8 + (g % 4), 3);
      wait_gnt("fair", 4'(1 << (g % 4)), 8 + (g % 4));
      gh[g] = 0;
      for (int b = 0; b < NREQ; b++) if (gnt[b]) gh[g] = b;
      wait_resp("fair", 100);
    end
    req = '0;
    for (int w = 0; w < 2; w++)
      for (int a = w; a < w + 4; a++)
        for (int b = a + 1; b < w + 4; b++)
          chk("fair_window", gh[a] != gh[b], 1'b1);

    // Backpressure on requester 1 while requester 3 waits.
    @(negedge clk);
    resp_ready = 1'b0; eng_busy = 4;
    set_n(1, 7); req = 4'b0010; push(1, 7, 4);
    wait_gnt("bp", 4'b0010, 7);
    set_n(3, 10); req = 4'b1000;
    wait_resp("bp", 100);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1'b1);
      chk("bp_hold_id", resp_id, last.id);
      chk("bp_hold_ans", resp_ans, last.ans);
      chk("bp_hold_cyc", resp_cycles, last.cyc);
      chk("bp_hold_start", eng_start, 0);
      chk("bp_hold_gnt", gnt, 0);
    end
    resp_ready = 1'b1;
    push(3, 10, 4);
    @(negedge clk);
    chk("bp_drop_valid", resp_valid, 0);
    chk("bp_bubble_gnt", gnt, 0);
    @(negedge clk);
    chk("bp_next_gnt", gnt, 4'b1000);
    chk("bp_next_eng_n", eng_n, 10);
    req = '0;
    wait_resp("bp_next", 100);

    // Done held high after start must not be taken as completion.
    @(negedge clk);
    eng_hi = 3; eng_busy = 5;
    set_n(0, 12); req = 4'b0001; push(0, 12, 5);
    wait_gnt("guard", 4'b0001, 12);
    req = '0;
    repeat (4) begin
      @(negedge clk);
      chk("guard_no_cap", resp_valid, 0);
    end
    wait_resp("guard", 100);

    // Cycle counter saturation.
    @(negedge clk);
    eng_hi = 0; eng_busy = 1500;
    set_n(1, 20); req = 4'b0010; push(1, 20, 1500);
    wait_gnt("sat", 4'b0010, 20);
    req = '0;
    wait_resp("sat", 2000);
    repeat (3) @(negedge clk);
    chk("end_idle_valid", resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fib_req_arbiter.md
FIB_REQ_ARBITER -- requirements
Module: fib_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter IDW, default 2: requester id width, clog2(NREQ).
REQ-003 Parameter CYW, default 10: engine cycle-count width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester request level.
REQ-007 req_n  in  5*NREQ  packed operand n, slice i = bits [5i+4:5i].
REQ-008 gnt  out  NREQ  one-hot accept pulse, one cycle.
REQ-009 resp_valid  out  1  result available.
REQ-010 resp_ready  in  1  consumer accepts result.
REQ-011 resp_id  out  IDW  id of the requester owning the result.
REQ-012 resp_ans  out  121  captured engine result.
REQ-013 resp_cycles  out  CYW  engine busy cycles for this result, saturating.
REQ-014 eng_start  out  1  start pulse to the shared Fibonacci engine.
REQ-015 eng_n  out  5  operand to the engine.
REQ-016 eng_done  in  1  engine done (high while the engine is idle).
REQ-017 eng_ans  in  121  engine result.

Function
REQ-018 FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP; one request in flight at a time.
REQ-019 IDLE: if any req bit is set, pick the first set bit at or above rr_ptr (wrapping); latch its id and req_n slice; go to LAUNCH. Otherwise stay in IDLE.
REQ-020 LAUNCH (one cycle): eng_start=1, gnt[id]=1, eng_n=latched n, cycle counter cleared; next state WAIT_BUSY.
REQ-021 eng_n holds the latched n from LAUNCH through WAIT_DONE; it is 0 in IDLE and RESP.
REQ-022 WAIT_BUSY: stay while eng_done=1; go to WAIT_DONE on the first cycle eng_done=0. A spurious completion is never accepted.
REQ-023 WAIT_DONE: the counter increments each cycle and saturates at 2^CYW-1. On eng_done=1, capture eng_ans and the counter into resp_ans and resp_cycles; go to RESP.
REQ-024 RESP: resp_valid=1 and resp_ans, resp_id, resp_cycles are held stable until resp_valid&resp_ready.
REQ-025 On the RESP handshake: rr_ptr=(id+1) mod NREQ; next state IDLE; resp_valid drops the next cycle.
REQ-026 A request arriving during the handshake cycle is arbitrated in the following IDLE cycle (one-cycle bubble).
REQ-027 A requester holds req and its n until its gnt; a req dropped before gnt is simply not selected, with no error.
REQ-028 Requests from non-selected requesters are never lost while held; the round-robin pointer guarantees service within NREQ transactions.
REQ-029 gnt, eng_start and resp_valid are registered outputs with no combinational path from req or eng_done.

Reset
REQ-030 Reset asserted (reset=0): state=IDLE, rr_ptr=0, all outputs 0 (gnt, resp_valid, resp_id, resp_ans, resp_cycles, eng_start, eng_n).
REQ-031 Reset mid-transaction aborts the transaction, discards any captured result and produces no gnt or resp; the engine's own reset is outside this block.
REQ-032 After reset deassertion, the first arbitration is on the first rising edge with a req bit set.

Structure
REQ-033 Shared package fib_arb_pkg: FSM state encoding, ANS_W=121, N_W=5, and defaults for NREQ, IDW and CYW.
REQ-034 One sub-module rr_picker (combinational): inputs req and rr_ptr; outputs valid and the selected id.
REQ-035 The FSM and all datapath registers live in fib_req_arbiter; no memories.

Verification
REQ-036 Single request: req=4'b0100, slice2 n=5, engine model returns ans=5 and holds done low for 6 cycles -> gnt=4'b0100 in LAUNCH; then resp_valid, resp_id=2, resp_ans=5, resp_cycles=6.
REQ-037 Fairness: req=4'b1111 held continuously with resp_ready=1 -> grant order 0,1,2,3,0 and no requester granted twice in any 4 consecutive grants.
REQ-038 Backpressure: resp_ready=0 for 10 cycles in RESP -> outputs stable, no eng_start, other req held pending; ready=1 -> handshake, then the next grant after the one-cycle bubble.
REQ-039 Done-high guard: engine model keeps done=1 for 3 cycles after start -> FSM stays in WAIT_BUSY with no capture; later completion returns the correct ans.
REQ-040 Reset mid-flight: reset=0 during WAIT_DONE -> all outputs 0 immediately; after release with req=4'b0001 -> gnt=4'b0001 (rr_ptr=0).
REQ-041 Saturation: engine busy for 1500 cycles with CYW=10 -> resp_cycles=1023.
